// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port data SRAM: pipeline MEM stage (p0)
// and loader/debug port (p1), round-robin with a bounded p1 lock mode.
module mem_arbiter #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [31:0]   p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [31:0]   p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [31:0]   p1_addr,
    input  logic [31:0]   p1_wdata,
    input  logic          p1_lock,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [31:0]   p1_rdata,
    output logic          stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RR    = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    // True when a byte address is misaligned or lies beyond the SRAM.
    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> (AW + 2)) != 32'd0);
    endfunction

    state_t      state_r, state_s;
    logic        ptr_r, ptr_s;       // last granted port: 0 = p0, 1 = p1
    logic [3:0]  lock_cnt_r, lock_cnt_s;
    logic        g0_s, g1_s;
    logic        bad0_s, bad1_s;
    logic        p0_rv_r, p1_rv_r;
    logic        bad_r;

    assign bad0_s = addr_bad(p0_addr);
    assign bad1_s = addr_bad(p1_addr);

    // Grant decision, next state, pointer and lock-counter update.
    always_comb begin
        g0_s       = 1'b0;
        g1_s       = 1'b0;
        state_s    = state_r;
        ptr_s      = ptr_r;
        lock_cnt_s = lock_cnt_r;
        if (rst_n) begin
            case (state_r)
                LOCK1: begin
                    // p0 breaks through after 8 locked p1 grants it waited on
                    if (p1_req && p1_lock && p0_req && (lock_cnt_r == 4'd8)) begin
                        g0_s = 1'b1;
                    end else if (p1_req) begin
                        g1_s = 1'b1;
                    end else if (p0_req) begin
                        g0_s = 1'b1;
                    end else begin
                        g0_s = 1'b0;
                    end
                end
                default: begin
                    if (p0_req && p1_req) begin
                        g0_s = ptr_r;
                        g1_s = ~ptr_r;
                    end else if (p0_req) begin
                        g0_s = 1'b1;
                    end else if (p1_req) begin
                        g1_s = 1'b1;
                    end else begin
                        g0_s = 1'b0;
                    end
                end
            endcase

            if (g1_s && p1_lock) begin
                state_s = LOCK1;
            end else if (p0_req || p1_req || p0_rv_r || p1_rv_r) begin
                state_s = RR;
            end else begin
                state_s = IDLE;
            end

            if (g0_s) begin
                ptr_s = 1'b0;
            end else if (g1_s) begin
                ptr_s = 1'b1;
            end else begin
                ptr_s = ptr_r;
            end

            if ((state_r == LOCK1) && (state_s == LOCK1) && g1_s) begin
                lock_cnt_s = p0_req ? (lock_cnt_r + 4'd1) : 4'd0;
            end else if (state_s != LOCK1) begin
                lock_cnt_s = 4'd0;
            end else begin
                lock_cnt_s = lock_cnt_r;
            end
        end else begin
            state_s = IDLE;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ptr_r      <= 1'b1;
            lock_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            lock_cnt_r <= lock_cnt_s;
        end
    end

    // Read-return and error tracking for the access granted this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_rv_r <= 1'b0;
            p1_rv_r <= 1'b0;
            bad_r   <= 1'b0;
        end else begin
            p0_rv_r <= g0_s & ~p0_we;
            p1_rv_r <= g1_s & ~p1_we;
            bad_r   <= (g0_s & bad0_s) | (g1_s & bad1_s);
        end
    end

    // SRAM command from the granted port; rejected addresses never reach the array.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = 32'd0;
        if (g0_s) begin
            mem_en    = ~bad0_s;
            mem_we    = p0_we;
            mem_addr  = p0_addr[AW+1:2];
            mem_wdata = p0_wdata;
        end else if (g1_s) begin
            mem_en    = ~bad1_s;
            mem_we    = p1_we;
            mem_addr  = p1_addr[AW+1:2];
            mem_wdata = p1_wdata;
        end else begin
            mem_en    = 1'b0;
        end
    end

    // A reset arriving while a read returns drops that return.
    assign p0_gnt    = g0_s;
    assign p1_gnt    = g1_s;
    assign p0_rvalid = p0_rv_r & rst_n;
    assign p1_rvalid = p1_rv_r & rst_n;
    assign p0_rdata  = (p0_rvalid && !bad_r) ? mem_rdata : 32'd0;
    assign p1_rdata  = (p1_rvalid && !bad_r) ? mem_rdata : 32'd0;
    assign stall     = p0_req & ~g0_s;
    assign err       = bad_r;

endmodule
